// File: rtl/prbs_chk_10b.sv
// prbs_chk_10b: serial checker for the 10-bit XNOR LFSR sequence
// (b[n+10] = ~(b[n+3] ^ b[n])). It self-synchronises in SEARCH, confirms the
// alignment in VERIFY, and then flywheels on its own predictions in LOCKED.
// In LOCKED it counts bit errors and drops back to SEARCH when the errors in
// one observation window reach LOSS_ERRS.
// Optional build macro PRBS_CHK_STICKY_LOSS_EN adds the sticky lost_lock output.
module prbs_chk_10b #(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned WINDOW     = 64,
  parameter int unsigned LOSS_ERRS  = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
`ifdef PRBS_CHK_STICKY_LOSS_EN
  output logic             lost_lock,
`endif
  output logic [1:0]       state_out
);

  localparam int unsigned HIST_W  = 10;
  localparam int unsigned FILL_W  = 4;
  localparam int unsigned MATCH_W = 8;
  localparam int unsigned WIN_W   = $clog2(WINDOW);
  localparam int unsigned WERR_W  = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t               state, state_nxt;
  logic [HIST_W-1:0]    hist, hist_nxt;
  logic [FILL_W-1:0]    fill, fill_nxt;
  logic [MATCH_W-1:0]   match, match_nxt;
  logic [WIN_W-1:0]     win, win_nxt;
  logic [WERR_W-1:0]    werr, werr_nxt;
  logic [ERR_W-1:0]     err_count_nxt;
  logic                 err_pulse_nxt;
`ifdef PRBS_CHK_STICKY_LOSS_EN
  logic                 lost_nxt;
`endif

  logic                 pred_c;
  logic                 mism_c;
  logic [HIST_W-1:0]    shift_rx_c;
  logic [MATCH_W-1:0]   match_inc_c;
  logic [WERR_W-1:0]    werr_inc_c;

  // Prediction of the next sequence bit and the candidate shifted history
  assign pred_c      = ~(hist[3] ^ hist[0]);
  assign mism_c      = in_bit ^ pred_c;
  assign shift_rx_c  = {in_bit, hist[HIST_W-1:1]};
  assign match_inc_c = match + MATCH_W'(1);
  assign werr_inc_c  = werr + WERR_W'(mism_c);

  assign state_out = state;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  // Next-state, history, counters and error bookkeeping
  always_comb begin
    state_nxt     = state;
    hist_nxt      = hist;
    fill_nxt      = fill;
    match_nxt     = match;
    win_nxt       = win;
    werr_nxt      = werr;
    err_count_nxt = err_count;
    err_pulse_nxt = 1'b0;
`ifdef PRBS_CHK_STICKY_LOSS_EN
    lost_nxt      = lost_lock;
`endif

    if (in_valid) begin
      case (state)
        SEARCH: begin
          hist_nxt = shift_rx_c;
          if (fill == FILL_W'(HIST_W - 1)) begin
            // Full history: all ones is the XNOR lock-up state, refill instead
            fill_nxt = '0;
            if (shift_rx_c != {HIST_W{1'b1}}) begin
              state_nxt = VERIFY;
              match_nxt = '0;
            end
          end else begin
            fill_nxt = fill + FILL_W'(1);
          end
        end

        VERIFY: begin
          // Received bits still feed the history until alignment is trusted
          hist_nxt = shift_rx_c;
          if (mism_c) begin
            match_nxt = '0;
          end else if (match_inc_c == MATCH_W'(LOCK_COUNT)) begin
            state_nxt = LOCKED;
            match_nxt = '0;
            win_nxt   = '0;
            werr_nxt  = '0;
          end else begin
            match_nxt = match_inc_c;
          end
        end

        LOCKED: begin
          // Flywheel: predicted bit is shifted so a bad bit is not propagated
          hist_nxt = {pred_c, hist[HIST_W-1:1]};
          win_nxt  = win + WIN_W'(1);
          if (mism_c) begin
            err_pulse_nxt = 1'b1;
            if (err_count != {ERR_W{1'b1}}) err_count_nxt = err_count + ERR_W'(1);
          end
          if (mism_c && (werr_inc_c == WERR_W'(LOSS_ERRS))) begin
            state_nxt = SEARCH;
            fill_nxt  = '0;
            win_nxt   = '0;
            werr_nxt  = '0;
          end else if (win == WIN_W'(WINDOW - 1)) begin
            // A wrapping error is carried into the new window
            werr_nxt = WERR_W'(mism_c);
          end else begin
            werr_nxt = werr_inc_c;
          end
        end

        default: begin
          state_nxt = SEARCH;
          fill_nxt  = '0;
        end
      endcase
    end

    if (clear_err) err_count_nxt = '0;

`ifdef PRBS_CHK_STICKY_LOSS_EN
    if (clear_err) lost_nxt = 1'b0;
    if ((state == LOCKED) && (state_nxt == SEARCH)) lost_nxt = 1'b1;
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist      <= '0;
      fill      <= '0;
      match     <= '0;
      win       <= '0;
      werr      <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
`ifdef PRBS_CHK_STICKY_LOSS_EN
      lost_lock <= 1'b0;
`endif
    end else begin
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      match     <= match_nxt;
      win       <= win_nxt;
      werr      <= werr_nxt;
      err_count <= err_count_nxt;
      err_pulse <= err_pulse_nxt;
      locked    <= (state_nxt == LOCKED);
`ifdef PRBS_CHK_STICKY_LOSS_EN
      lost_lock <= lost_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_prbs_chk_10b.sv
// tb_prbs_chk_10b: table-driven vectors, hand-written corner sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_prbs_chk_10b;

  localparam int unsigned LOCK_COUNT = 16;
  localparam int unsigned WINDOW     = 64;
  localparam int unsigned LOSS_ERRS  = 4;
  localparam int unsigned ERR_W      = 4;
  localparam int          ERR_MAX    = (1 << ERR_W) - 1;
  localparam logic [9:0]  SEED       = 10'b0011001001;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_bit;
  logic             clear_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state_out;
`ifdef PRBS_CHK_STICKY_LOSS_EN
  logic             lost_lock;
`endif

  prbs_chk_10b #(
    .LOCK_COUNT(LOCK_COUNT),
    .WINDOW    (WINDOW),
    .LOSS_ERRS (LOSS_ERRS),
    .ERR_W     (ERR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .clear_err(clear_err),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
`ifdef PRBS_CHK_STICKY_LOSS_EN
    .lost_lock(lost_lock),
`endif
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transmitter: last ten sequence bits, oldest first
  bit gen_q[$];
  // Reference model: mode 0 SEARCH, 1 VERIFY, 2 LOCKED
  int m_mode;
  bit m_hist[$];
  int m_match, m_nwin, m_werr, m_errs;
  bit m_pulse, m_lost;

  typedef struct {
    int         nbits;
    bit         flip;
    bit         clr;
    logic [1:0] st;
    bit         lk;
    bit         pl;
    int         cnt;
  } vec_t;
  vec_t tbl[17];

  task automatic gen_seed(input logic [9:0] s);
    gen_q.delete();
    for (int i = 0; i < 10; i++) gen_q.push_back(s[i]);
  endtask

  function automatic bit gen_next();
    bit o;
    bit n;
    n = ~(gen_q[3] ^ gen_q[0]);
    o = gen_q.pop_front();
    gen_q.push_back(n);
    return o;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_hist.delete();
    m_match = 0; m_nwin = 0; m_werr = 0; m_errs = 0;
    m_pulse = 1'b0; m_lost = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit c);
    bit p;
    bit err;
    bit lost_evt;
    int ones;
    m_pulse  = 1'b0;
    lost_evt = 1'b0;
    if (v) begin
      if (m_mode == 0) begin
        m_hist.push_back(b);
        if (m_hist.size() == 10) begin
          ones = 0;
          foreach (m_hist[i]) ones += int'(m_hist[i]);
          if (ones == 10) m_hist.delete();
          else begin m_mode = 1; m_match = 0; end
        end
      end else if (m_mode == 1) begin
        p = ~(m_hist[3] ^ m_hist[0]);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
        if (b == p) begin
          m_match++;
          if (m_match == int'(LOCK_COUNT)) begin m_mode = 2; m_nwin = 0; m_werr = 0; end
        end else m_match = 0;
      end else begin
        p = ~(m_hist[3] ^ m_hist[0]);
        m_hist.push_back(p);
        void'(m_hist.pop_front());
        err = (b != p);
        m_nwin++;
        if (err) begin
          m_pulse = 1'b1;
          if (m_errs < ERR_MAX) m_errs++;
          m_werr++;
        end
        if (err && m_werr == int'(LOSS_ERRS)) begin
          m_mode = 0; m_hist.delete(); lost_evt = 1'b1;
        end else if (m_nwin == int'(WINDOW)) begin
          m_nwin = 0;
          m_werr = err ? 1 : 0;
        end
      end
    end
    if (c) begin m_errs = 0; m_lost = 1'b0; end
    if (lost_evt) m_lost = 1'b1;
  endtask

  task automatic check_step(input string tag);
    bit ok;
    ok = (state_out === 2'(m_mode)) && (locked === (m_mode == 2)) &&
         (err_pulse === m_pulse) && (err_count === ERR_W'(m_errs));
`ifdef PRBS_CHK_STICKY_LOSS_EN
    ok = ok && (lost_lock === m_lost);
`endif
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s @%0t: got state=%b locked=%b pulse=%b count=%0d, want state=%b locked=%b pulse=%b count=%0d",
               tag, $time, state_out, locked, err_pulse, err_count,
               2'(m_mode), (m_mode == 2), m_pulse, m_errs);
    end
  endtask

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit b, input bit c, input string tag);
    in_valid = v; in_bit = b; clear_err = c;
    @(posedge clk); #1;
    model_step(v, b, c);
    check_step(tag);
  endtask

  task automatic send(input bit f, input bit c, input string tag);
    bit b;
    b = gen_next() ^ f;
    drive(1'b1, b, c, tag);
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, tag);
  endtask

  task automatic do_reset(input logic [9:0] s);
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_err = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    gen_seed(s);
  endtask

  // Stimulus and checks
  initial begin
    int nvalid;
    bit v, f, c;
    int rate;

    tbl[0]  = '{9,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 0};
    tbl[1]  = '{1,  1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 0};
    tbl[2]  = '{15, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 0};
    tbl[3]  = '{1,  1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 0};
    tbl[4]  = '{73, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 0};
    tbl[5]  = '{1,  1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1};
    tbl[6]  = '{1,  1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1};
    tbl[7]  = '{59, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2};
    tbl[8]  = '{10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 3};
    tbl[9]  = '{10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 4};
    tbl[10] = '{10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5};
    tbl[11] = '{9,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5};
    tbl[12] = '{1,  1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 5};
    tbl[13] = '{15, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 5};
    tbl[14] = '{1,  1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 5};
    tbl[15] = '{1,  1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 0};
    tbl[16] = '{9,  1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 0};

    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_err = 1'b0;
    do_reset(SEED);
    check_val("reset state_out", int'(state_out), 0);
    check_val("reset locked",    int'(locked), 0);
    check_val("reset err_pulse", int'(err_pulse), 0);
    check_val("reset err_count", int'(err_count), 0);

    // Table: clean lock, single error, window loss, relock, clear_err
    for (int r = 0; r < 17; r++) begin
      for (int i = 0; i < tbl[r].nbits; i++)
        send(tbl[r].flip && (i == tbl[r].nbits - 1), tbl[r].clr && (i == tbl[r].nbits - 1), "table");
      check_val($sformatf("tbl%0d state_out", r), int'(state_out), int'(tbl[r].st));
      check_val($sformatf("tbl%0d locked", r),    int'(locked),    int'(tbl[r].lk));
      check_val($sformatf("tbl%0d err_pulse", r), int'(err_pulse), int'(tbl[r].pl));
      check_val($sformatf("tbl%0d err_count", r), int'(err_count), tbl[r].cnt);
    end

    // Clean stream for 1000 bits: no errors counted
    do_reset(SEED);
    for (int i = 0; i < 1000; i++) send(1'b0, 1'b0, "clean1000");
    check_val("clean1000 locked", int'(locked), 1);
    check_val("clean1000 err_count", int'(err_count), 0);

    // All-ones stream never leaves SEARCH
    do_reset(SEED);
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 1'b0, "all_ones");
    check_val("all_ones state_out", int'(state_out), 0);

    // Gapped valid 1,0,0,1 pattern locks after 26 valid bits
    do_reset(SEED);
    nvalid = 0;
    for (int cyc = 0; cyc < 200 && nvalid < 26; cyc++) begin
      if ((cyc % 4 == 0) || (cyc % 4 == 3)) begin
        send(1'b0, 1'b0, "gap");
        nvalid++;
        if (nvalid == 25) check_val("gap pre-lock locked", int'(locked), 0);
      end else idle("gap");
    end
    check_val("gap valid budget", nvalid, 26);
    check_val("gap locked", int'(locked), 1);
    send(1'b1, 1'b0, "gap err");
    check_val("gap err_pulse", int'(err_pulse), 1);
    idle("gap idle");
    idle("gap idle");
    check_val("gap err_count", int'(err_count), 1);

    // Asynchronous reset mid-LOCKED, observed before any clock edge
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_val("async locked",    int'(locked), 0);
    check_val("async err_count", int'(err_count), 0);
    check_val("async state_out", int'(state_out), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    gen_seed(SEED);

    // Three errors per window over five windows, then saturation
    for (int i = 0; i < 26; i++) send(1'b0, 1'b0, "win_lock");
    check_val("win lock", int'(locked), 1);
    for (int w = 0; w < 5; w++)
      for (int k = 0; k < 64; k++)
        send((k == 5) || (k == 20) || (k == 40), 1'b0, "win3");
    check_val("win3 locked", int'(locked), 1);
    check_val("win3 err_count", int'(err_count), 15);
    for (int k = 0; k < 64; k++) begin
      send(k == 5, 1'b0, "sat");
      if (k == 5) begin
        check_val("sat err_count", int'(err_count), ERR_MAX);
        check_val("sat err_pulse", int'(err_pulse), 1);
      end
    end

    // Error on the wrapping bit carries into the next window
    for (int k = 0; k < 64; k++) send(k >= 61, 1'b0, "wrap");
    check_val("wrap locked", int'(locked), 1);
    send(1'b1, 1'b0, "wrap k0");
    send(1'b1, 1'b0, "wrap k1");
    check_val("wrap k1 locked", int'(locked), 1);
    send(1'b1, 1'b0, "wrap k2");
    check_val("wrap k2 locked", int'(locked), 0);
    check_val("wrap k2 state_out", int'(state_out), 0);

    // Randomized run against the reference model
    rate = 16;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 800 == 0) begin
        do_reset(10'($urandom_range(0, 1022)));
        rate = (rate == 16) ? 300 : 16;
      end
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, rate - 1) == 0);
      c = ($urandom_range(0, 199) == 0);
      if (v) send(f, c, "random");
      else   drive(1'b0, 1'($urandom_range(0, 1)), c, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Time limit so the run always ends
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: time limit reached before end of test");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
